// File: rtl/tape_register_if.sv
// Tape store port bundle: control side drives ops, store returns head view.
interface tape_register_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                  clear;
  logic                  step;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            move;
  logic [DATA_WIDTH-1:0] head_data;
  logic [AW-1:0]         head_pos;
  logic                  at_left;
  logic                  at_right;
  logic                  error;

  modport master (
    output clear, step, wr_en, wr_data, move,
    input  head_data, head_pos, at_left, at_right, error
  );

  modport slave (
    input  clear, step, wr_en, wr_data, move,
    output head_data, head_pos, at_left, at_right, error
  );
endinterface

// File: rtl/tape_register.sv
// Turing-machine tape: DEPTH symbol cells, a movable head,
// boundary decodes and a sticky off-the-end error flag.
module tape_register #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] BLANK      = '0,
  parameter int                    START_POS  = 0,
  parameter bit                    WRAP       = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  tape_register_if.slave bus
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] HOME = AW'(START_POS);

  logic [DATA_WIDTH-1:0] cells [DEPTH];
  logic [AW-1:0]         head;
  logic [AW-1:0]         head_nxt;
  logic                  err;
  logic                  err_hit;
  logic                  go_left;
  logic                  go_right;

  assign go_left  = bus.step && (bus.move == 2'b01);
  assign go_right = bus.step && (bus.move == 2'b10);

  // Ends are detected by compare so non-power-of-two depths wrap correctly.
  always_comb begin
    head_nxt = head;
    err_hit  = 1'b0;
    unique case (1'b1)
      go_left: begin
        if (head == '0) begin
          if (WRAP) head_nxt = LAST;
          else      err_hit  = 1'b1;
        end else begin
          head_nxt = head - 1'b1;
        end
      end
      go_right: begin
        if (head == LAST) begin
          if (WRAP) head_nxt = '0;
          else      err_hit  = 1'b1;
        end else begin
          head_nxt = head + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cells[i] <= BLANK;
    end else if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) cells[i] <= BLANK;
    end else if (bus.step && bus.wr_en) begin
      cells[head] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= HOME;
      err  <= 1'b0;
    end else if (bus.clear) begin
      head <= HOME;
      err  <= 1'b0;
    end else if (bus.step) begin
      head <= head_nxt;
      err  <= err | err_hit;
    end
  end

  assign bus.head_data = cells[head];
  assign bus.head_pos  = head;
  assign bus.at_left   = (head == '0);
  assign bus.at_right  = (head == LAST);
  assign bus.error     = err;
endmodule

// File: tb/tb_tape_register.sv
// Directed bench: default saturating tape plus a 5-cell wrapping tape.
module tb_tape_register;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tape_register_if #(.DATA_WIDTH(8), .DEPTH(16)) b0 ();
  tape_register_if #(.DATA_WIDTH(8), .DEPTH(5))  b1 ();

  tape_register u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  tape_register #(.DEPTH(5), .WRAP(1'b1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(input logic c, input logic s, input logic w,
                     input logic [7:0] d, input logic [1:0] m);
    b0.clear   = c;
    b0.step    = s;
    b0.wr_en   = w;
    b0.wr_data = d;
    b0.move    = m;
  endtask

  task automatic op1(input logic s, input logic [1:0] m);
    b1.clear   = 1'b0;
    b1.step    = s;
    b1.wr_en   = 1'b0;
    b1.wr_data = 8'h00;
    b1.move    = m;
  endtask

  task automatic look0(input string tag, input int pos, input int data,
                       input int err);
    chk({tag, ".pos"},  32'(b0.head_pos),  32'(pos));
    chk({tag, ".data"}, 32'(b0.head_data), 32'(data));
    chk({tag, ".err"},  32'(b0.error),     32'(err));
  endtask

  initial begin
    int exp_pos [5];
    exp_pos = '{1, 2, 3, 4, 0};
    op0(1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    op1(1'b0, 2'b00);

    // 1: async reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    look0("rst", 0, 0, 0);
    chk("rst.left",  32'(b0.at_left),  1);
    chk("rst.right", 32'(b0.at_right), 0);
    chk("rst.u1pos", 32'(b1.head_pos), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 2: write and move right, then back left
    op0(1'b0, 1'b1, 1'b1, 8'hA5, 2'b10);
    tick();
    look0("wr_r", 1, 0, 0);
    chk("wr_r.left", 32'(b0.at_left), 0);
    op0(1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
    tick();
    look0("mv_l", 0, 8'hA5, 0);
    op0(1'b0, 1'b0, 1'b1, 8'h11, 2'b10);
    tick();
    look0("idle", 0, 8'hA5, 0);

    // 3: left at 0 saturates, write lands, error sticks
    op0(1'b0, 1'b1, 1'b1, 8'h3C, 2'b01);
    tick();
    look0("sat_l", 0, 8'h3C, 1);
    op0(1'b0, 1'b1, 1'b0, 8'h00, 2'b10);
    tick();
    look0("sticky", 1, 0, 1);
    op0(1'b0, 1'b1, 1'b0, 8'h00, 2'b11);
    tick();
    look0("rsvd", 1, 0, 1);
    op0(1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
    tick();
    look0("clr", 0, 0, 0);

    // 5: fill cells 0..3, then clear+step together
    for (int i = 0; i < 4; i++) begin
      op0(1'b0, 1'b1, 1'b1, 8'hFF, 2'b10);
      tick();
    end
    look0("fill", 4, 0, 0);
    op0(1'b1, 1'b1, 1'b1, 8'h77, 2'b10);
    tick();
    look0("clrstep", 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      op0(1'b0, 1'b1, 1'b0, 8'h00, 2'b10);
      tick();
      chk($sformatf("blank%0d", i), 32'(b0.head_data), 0);
    end

    // right end: walk to 15, then push past it
    for (int i = 5; i <= 15; i++) begin
      op0(1'b0, 1'b1, 1'b0, 8'h00, 2'b10);
      tick();
    end
    chk("end.pos",   32'(b0.head_pos), 15);
    chk("end.right", 32'(b0.at_right), 1);
    chk("end.err",   32'(b0.error),    0);
    op0(1'b0, 1'b1, 1'b1, 8'hC3, 2'b10);
    tick();
    look0("sat_r", 15, 8'hC3, 1);
    op0(1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
    tick();
    op0(1'b0, 1'b0, 1'b0, 8'h00, 2'b00);

    // 4: wrapping 5-cell tape
    for (int i = 0; i < 5; i++) begin
      op1(1'b1, 2'b10);
      tick();
      chk($sformatf("wrap%0d.pos", i), 32'(b1.head_pos), 32'(exp_pos[i]));
      chk($sformatf("wrap%0d.right", i), 32'(b1.at_right),
          (exp_pos[i] == 4) ? 1 : 0);
      chk($sformatf("wrap%0d.err", i), 32'(b1.error), 0);
    end
    op1(1'b1, 2'b01);
    tick();
    chk("wrap_l.pos", 32'(b1.head_pos), 4);
    chk("wrap_l.err", 32'(b1.error),    0);
    op1(1'b0, 2'b00);

    // 6: async reset between edges during a write sequence
    op0(1'b0, 1'b1, 1'b1, 8'h5A, 2'b00);
    tick();
    look0("pre", 0, 8'h5A, 0);
    op0(1'b0, 1'b1, 1'b1, 8'h99, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    look0("arst", 0, 0, 0);
    chk("arst.u1pos", 32'(b1.head_pos), 0);
    tick();
    look0("arst_edge", 0, 0, 0);
    rst_n = 1'b1;
    op0(1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    tick();
    look0("post", 0, 0, 0);
    op0(1'b0, 1'b1, 1'b0, 8'h00, 2'b10);
    tick();
    look0("post1", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
